// File: rtl/pipe_stage_hs.sv
// Generic inter-stage pipeline register with valid/ready handshake.
// Carries one WIDTH-bit payload per entry. Supports hazard stall, flush,
// bubble zeroing, and an optional skid entry so in_ready depends only on
// registered state.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake, in_data is the offered payload
//   stall               freeze: hold contents, accept nothing, present nothing
//   flush               invalidate every held entry at the next edge
//   out_valid/out_ready downstream handshake, out_data is the oldest entry
//   occupancy           number of entries currently held
module pipe_stage_hs #(
   parameter int unsigned      WIDTH       = 128,
   parameter bit               SKID        = 1'b1,
   parameter bit               ZERO_BUBBLE = 1'b1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             stall,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   // Payload registers reload to this value so a stale-payload stage still
   // shows 0 after reset.
   localparam logic [WIDTH-1:0] RST_DATA = ZERO_BUBBLE ? RESET_VALUE : '0;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_MAIN  = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] main_data;
   logic [WIDTH-1:0] main_nxt;
   logic [WIDTH-1:0] skid_data;
   logic [WIDTH-1:0] skid_nxt;
   logic             out_valid_int;
   logic             in_xfer;
   logic             out_xfer;

   // State and payload registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_EMPTY;
         main_data <= RST_DATA;
         skid_data <= RST_DATA;
      end else begin
         state     <= state_nxt;
         main_data <= main_nxt;
         skid_data <= skid_nxt;
      end
   end

   // Handshake outputs. With SKID=0 the FULL state is unreachable because
   // in_ready requires the main entry to drain in the same cycle.
   always_comb begin
      out_valid_int = (state != S_EMPTY);
      out_valid     = out_valid_int & ~stall;
      if (SKID) begin
         in_ready = ~rst & ~stall & (state != S_FULL);
      end else begin
         in_ready = ~rst & ~stall & (~out_valid_int | out_ready);
      end
      in_xfer   = in_valid & in_ready;
      out_xfer  = out_valid & out_ready;
      out_data  = (out_valid_int || !ZERO_BUBBLE) ? main_data : RESET_VALUE;
      occupancy = 2'(state);
   end

   // Next state and payload movement; flush beats stall beats handshake.
   always_comb begin
      state_nxt = state;
      main_nxt  = main_data;
      skid_nxt  = skid_data;
      if (flush) begin
         state_nxt = S_EMPTY;
      end else if (!stall) begin
         case (state)
            S_EMPTY: begin
               if (in_xfer) begin
                  state_nxt = S_MAIN;
                  main_nxt  = in_data;
               end
            end
            S_MAIN: begin
               if (in_xfer && out_xfer) begin
                  main_nxt = in_data;
               end else if (in_xfer) begin
                  state_nxt = S_FULL;
                  skid_nxt  = in_data;
               end else if (out_xfer) begin
                  state_nxt = S_EMPTY;
               end
            end
            S_FULL: begin
               if (out_xfer) begin
                  state_nxt = S_MAIN;
                  main_nxt  = skid_data;
               end
            end
            default: state_nxt = S_EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: directed vector tables for both skid options,
// a mid-traffic reset sequence, and a randomized scoreboard phase.
module tb_pipe_stage_hs;
   localparam int unsigned W = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst;
   logic [1:0]          iv, st, fl, ordy;
   logic [1:0][W-1:0]   id;
   logic [1:0]          ir, ov;
   logic [1:0][W-1:0]   od;
   logic [1:0][1:0]     occ;

   logic                s0_ir, s0_ov, s1_ir, s1_ov;
   logic [W-1:0]        s0_od, s1_od;
   logic [1:0]          s0_occ, s1_occ;

   assign ir  = {s1_ir, s0_ir};
   assign ov  = {s1_ov, s0_ov};
   assign od  = {s1_od, s0_od};
   assign occ = {s1_occ, s0_occ};

   int n_cmp = 0;
   int n_err = 0;

   // index 0: single-entry stage, index 1: skid-buffered stage
   pipe_stage_hs #(.WIDTH(W), .SKID(1'b0), .ZERO_BUBBLE(1'b1), .RESET_VALUE('0)) u_s0 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(s0_ir), .in_data(id[0]),
      .stall(st[0]), .flush(fl[0]), .out_valid(s0_ov), .out_ready(ordy[0]),
      .out_data(s0_od), .occupancy(s0_occ));

   pipe_stage_hs #(.WIDTH(W), .SKID(1'b1), .ZERO_BUBBLE(1'b1), .RESET_VALUE('0)) u_s1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(s1_ir), .in_data(id[1]),
      .stall(st[1]), .flush(fl[1]), .out_valid(s1_ov), .out_ready(ordy[1]),
      .out_data(s1_od), .occupancy(s1_occ));

   typedef struct {
      logic         iv;
      logic [W-1:0] d;
      logic         st;
      logic         fl;
      logic         rd;
      logic         ov;
      logic [W-1:0] od;
      logic         ir;
      logic [1:0]   occ;
   } vec_t;

   function automatic vec_t mk(input logic v_iv, input logic [W-1:0] v_d, input logic v_st,
                               input logic v_fl, input logic v_rd, input logic v_ov,
                               input logic [W-1:0] v_od, input logic v_ir, input logic [1:0] v_occ);
      vec_t v;
      v.iv = v_iv; v.d = v_d; v.st = v_st; v.fl = v_fl; v.rd = v_rd;
      v.ov = v_ov; v.od = v_od; v.ir = v_ir; v.occ = v_occ;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one vector at the falling edge, compare just after, before the next rising edge.
   task automatic run_vec(input int sel, input vec_t v, input string tag);
      @(negedge clk);
      iv[sel] = v.iv; id[sel] = v.d; st[sel] = v.st; fl[sel] = v.fl; ordy[sel] = v.rd;
      #1;
      chk({tag, ".out_valid"}, 32'(ov[sel]), 32'(v.ov));
      chk({tag, ".out_data"},  32'(od[sel]), 32'(v.od));
      chk({tag, ".in_ready"},  32'(ir[sel]), 32'(v.ir));
      chk({tag, ".occupancy"}, 32'(occ[sel]), 32'(v.occ));
   endtask

   vec_t t1[28];
   vec_t t0[9];

   int           head[2];
   int           cnt[2];
   logic [W-1:0] mq[2][4];

   initial begin
      // skid-buffered stage: streaming, backpressure, stall, flush, flush+stall
      t1[0]  = mk(1'b1, 16'h1,  1'b0, 1'b0, 1'b1,  1'b0, 16'h0,  1'b1, 2'd0);
      t1[1]  = mk(1'b1, 16'h2,  1'b0, 1'b0, 1'b1,  1'b1, 16'h1,  1'b1, 2'd1);
      t1[2]  = mk(1'b1, 16'h3,  1'b0, 1'b0, 1'b1,  1'b1, 16'h2,  1'b1, 2'd1);
      t1[3]  = mk(1'b0, 16'h0,  1'b0, 1'b0, 1'b1,  1'b1, 16'h3,  1'b1, 2'd1);
      t1[4]  = mk(1'b0, 16'h0,  1'b0, 1'b0, 1'b0,  1'b0, 16'h0,  1'b1, 2'd0);
      t1[5]  = mk(1'b1, 16'hA,  1'b0, 1'b0, 1'b0,  1'b0, 16'h0,  1'b1, 2'd0);
      t1[6]  = mk(1'b1, 16'hB,  1'b0, 1'b0, 1'b0,  1'b1, 16'hA,  1'b1, 2'd1);
      t1[7]  = mk(1'b1, 16'hC,  1'b0, 1'b0, 1'b0,  1'b1, 16'hA,  1'b0, 2'd2);
      t1[8]  = mk(1'b0, 16'h0,  1'b0, 1'b0, 1'b1,  1'b1, 16'hA,  1'b0, 2'd2);
      t1[9]  = mk(1'b0, 16'h0,  1'b0, 1'b0, 1'b1,  1'b1, 16'hB,  1'b1, 2'd1);
      t1[10] = mk(1'b0, 16'h0,  1'b0, 1'b0, 1'b0,  1'b0, 16'h0,  1'b1, 2'd0);
      t1[11] = mk(1'b1, 16'h55, 1'b0, 1'b0, 1'b0,  1'b0, 16'h0,  1'b1, 2'd0);
      for (int i = 12; i < 16; i++)
         t1[i] = mk(1'b1, 16'h66, 1'b1, 1'b0, 1'b1,  1'b0, 16'h55, 1'b0, 2'd1);
      t1[16] = mk(1'b0, 16'h0,  1'b0, 1'b0, 1'b0,  1'b1, 16'h55, 1'b1, 2'd1);
      t1[17] = mk(1'b0, 16'h0,  1'b0, 1'b0, 1'b1,  1'b1, 16'h55, 1'b1, 2'd1);
      t1[18] = mk(1'b1, 16'h11, 1'b0, 1'b0, 1'b0,  1'b0, 16'h0,  1'b1, 2'd0);
      t1[19] = mk(1'b1, 16'h22, 1'b0, 1'b0, 1'b0,  1'b1, 16'h11, 1'b1, 2'd1);
      t1[20] = mk(1'b1, 16'h77, 1'b0, 1'b1, 1'b0,  1'b1, 16'h11, 1'b0, 2'd2);
      t1[21] = mk(1'b0, 16'h0,  1'b0, 1'b0, 1'b0,  1'b0, 16'h0,  1'b1, 2'd0);
      t1[22] = mk(1'b1, 16'h33, 1'b0, 1'b0, 1'b0,  1'b0, 16'h0,  1'b1, 2'd0);
      t1[23] = mk(1'b1, 16'h77, 1'b0, 1'b1, 1'b0,  1'b1, 16'h33, 1'b1, 2'd1);
      t1[24] = mk(1'b0, 16'h0,  1'b0, 1'b0, 1'b1,  1'b0, 16'h0,  1'b1, 2'd0);
      t1[25] = mk(1'b1, 16'h44, 1'b0, 1'b0, 1'b0,  1'b0, 16'h0,  1'b1, 2'd0);
      t1[26] = mk(1'b1, 16'h88, 1'b1, 1'b1, 1'b1,  1'b0, 16'h44, 1'b0, 2'd1);
      t1[27] = mk(1'b0, 16'h0,  1'b0, 1'b0, 1'b1,  1'b0, 16'h0,  1'b1, 2'd0);

      // single-entry stage: in_ready follows out_ready, stall hold
      t0[0] = mk(1'b1, 16'h5, 1'b0, 1'b0, 1'b0,  1'b0, 16'h0, 1'b1, 2'd0);
      t0[1] = mk(1'b1, 16'h6, 1'b0, 1'b0, 1'b0,  1'b1, 16'h5, 1'b0, 2'd1);
      t0[2] = mk(1'b1, 16'h6, 1'b0, 1'b0, 1'b1,  1'b1, 16'h5, 1'b1, 2'd1);
      t0[3] = mk(1'b0, 16'h0, 1'b0, 1'b0, 1'b1,  1'b1, 16'h6, 1'b1, 2'd1);
      t0[4] = mk(1'b0, 16'h0, 1'b0, 1'b0, 1'b0,  1'b0, 16'h0, 1'b1, 2'd0);
      t0[5] = mk(1'b1, 16'h9, 1'b0, 1'b0, 1'b0,  1'b0, 16'h0, 1'b1, 2'd0);
      t0[6] = mk(1'b1, 16'h7, 1'b1, 1'b0, 1'b1,  1'b0, 16'h9, 1'b0, 2'd1);
      t0[7] = mk(1'b0, 16'h0, 1'b0, 1'b0, 1'b1,  1'b1, 16'h9, 1'b1, 2'd1);
      t0[8] = mk(1'b0, 16'h0, 1'b0, 1'b0, 1'b0,  1'b0, 16'h0, 1'b1, 2'd0);

      rst = 1'b1; iv = '0; st = '0; fl = '0; ordy = '0; id = '0;

      // power-on reset
      @(negedge clk); #1;
      chk("por.in_ready0", 32'(ir[0]), 32'h0);
      chk("por.in_ready1", 32'(ir[1]), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      for (int s = 0; s < 2; s++) begin
         chk($sformatf("por%0d.in_ready", s),  32'(ir[s]),  32'h1);
         chk($sformatf("por%0d.out_valid", s), 32'(ov[s]),  32'h0);
         chk($sformatf("por%0d.out_data", s),  32'(od[s]),  32'h0);
         chk($sformatf("por%0d.occupancy", s), 32'(occ[s]), 32'h0);
      end

      for (int i = 0; i < 28; i++) run_vec(1, t1[i], $sformatf("skid1.v%0d", i));
      for (int i = 0; i < 9; i++)  run_vec(0, t0[i], $sformatf("skid0.v%0d", i));

      // reset held 3 cycles while the skid stage is full
      @(negedge clk);
      iv[1] = 1'b1; id[1] = 16'h5A; ordy[1] = 1'b0; #1;
      chk("rst.fill0.occ", 32'(occ[1]), 32'h0);
      @(negedge clk);
      id[1] = 16'h5B; #1;
      chk("rst.fill1.occ", 32'(occ[1]), 32'h1);
      @(negedge clk);
      rst = 1'b1; id[1] = 16'h5C; ordy[1] = 1'b1; #1;
      chk("rst.c0.in_ready", 32'(ir[1]), 32'h0);
      chk("rst.c0.occ", 32'(occ[1]), 32'h2);
      for (int k = 1; k < 3; k++) begin
         @(negedge clk); #1;
         chk($sformatf("rst.c%0d.in_ready", k),  32'(ir[1]),  32'h0);
         chk($sformatf("rst.c%0d.occ", k),       32'(occ[1]), 32'h0);
         chk($sformatf("rst.c%0d.out_valid", k), 32'(ov[1]),  32'h0);
         chk($sformatf("rst.c%0d.out_data", k),  32'(od[1]),  32'h0);
      end
      @(negedge clk);
      rst = 1'b0; iv = '0; ordy = '0; #1;
      chk("rst.rel.in_ready",  32'(ir[1]),  32'h1);
      chk("rst.rel.occ",       32'(occ[1]), 32'h0);
      chk("rst.rel.out_valid", 32'(ov[1]),  32'h0);
      chk("rst.rel.out_data",  32'(od[1]),  32'h0);

      // randomized traffic on both stages against an order-preserving model
      for (int s = 0; s < 2; s++) begin
         head[s] = 0;
         cnt[s]  = 0;
      end
      for (int c = 0; c < 10000; c++) begin
         @(negedge clk);
         for (int s = 0; s < 2; s++) begin
            iv[s]   = ($urandom_range(0, 9) < 7);
            id[s]   = W'($urandom);
            st[s]   = ($urandom_range(0, 9) == 0);
            fl[s]   = ($urandom_range(0, 29) == 0);
            ordy[s] = ($urandom_range(0, 9) < 6);
         end
         #1;
         for (int s = 0; s < 2; s++) begin
            logic e_ov, e_ir, in_x, out_x;
            e_ov = (cnt[s] != 0) && !st[s];
            if (s == 1) e_ir = !st[s] && (cnt[s] < 2);
            else        e_ir = !st[s] && ((cnt[s] == 0) || ordy[s]);
            chk($sformatf("rnd%0d.out_valid", s), 32'(ov[s]),  32'(e_ov));
            chk($sformatf("rnd%0d.in_ready", s),  32'(ir[s]),  32'(e_ir));
            chk($sformatf("rnd%0d.occupancy", s), 32'(occ[s]), 32'(cnt[s]));
            if (cnt[s] != 0) chk($sformatf("rnd%0d.out_data", s), 32'(od[s]), 32'(mq[s][head[s]]));
            else             chk($sformatf("rnd%0d.bubble", s),   32'(od[s]), 32'h0);
            in_x  = iv[s] & e_ir;
            out_x = e_ov & ordy[s];
            if (fl[s]) begin
               cnt[s] = 0;
            end else begin
               if (out_x) begin
                  head[s] = (head[s] + 1) % 4;
                  cnt[s]  = cnt[s] - 1;
               end
               if (in_x) begin
                  mq[s][(head[s] + cnt[s]) % 4] = id[s];
                  cnt[s] = cnt[s] + 1;
               end
            end
         end
      end

      @(negedge clk);
      iv = '0; st = '0; fl = '0; ordy = '0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
